// File: rtl/chan_fifo_pkg.sv
// Shared types, constants and the round-robin helper for the chan_fifo_arb slice.
package chan_fifo_pkg;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_HOLD  = 1'b1
  } out_state_t;

  localparam int STALL_W  = 16;
  // Widest lane count the round-robin helper can search.
  localparam int MAX_CHAN = 32;

  // Returns the first requesting lane after 'last' (wrapping), or 'last' if none request.
  function automatic int next_rr(input int last, input logic [MAX_CHAN-1:0] req_mask,
                                 input int nchan);
    int   idx;
    int   res;
    logic found;
    res   = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_CHAN; k++) begin
      if (!found && k <= nchan) begin
        idx = last + k;
        if (idx >= nchan) idx = idx - nchan;
        if (req_mask[idx[4:0]]) begin
          res   = idx;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/chan_fifo_lane.sv
// Single-lane DEPTH x WIDTH FIFO with natural-wrap pointers and an occupancy count.
module chan_fifo_lane
  import chan_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/chan_fifo_arb.sv
// NCHAN buffered lanes merged round-robin onto one valid/ready output register.
// Optional per-lane stall counters are built when CHAN_FIFO_STALL_CNT_EN is defined.
module chan_fifo_arb
  import chan_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int NCHAN = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCHAN-1:0]                    in_valid,
  input  logic [NCHAN*WIDTH-1:0]              in_data,
  output logic [NCHAN-1:0]                    in_ready,
  output logic                                out_valid,
  output logic [WIDTH-1:0]                    out_data,
  output logic [$clog2(NCHAN)-1:0]            out_chan,
  input  logic                                out_ready,
  output logic [NCHAN*($clog2(DEPTH)+1)-1:0]  level
`ifdef CHAN_FIFO_STALL_CNT_EN
  ,
  output logic [NCHAN*STALL_W-1:0]            stall_count
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(NCHAN);

  logic [NCHAN-1:0]            w_full;
  logic [NCHAN-1:0]            w_empty;
  logic [NCHAN-1:0]            w_push;
  logic [NCHAN-1:0]            w_pop;
  logic [NCHAN-1:0][WIDTH-1:0] w_lane_data;
  logic [NCHAN-1:0][LW-1:0]    w_count;
  logic [NCHAN-1:0]            w_req;
  logic                        w_load;
  logic                        w_take;
  logic [CW-1:0]               w_grant;
  out_state_t                  w_state_nxt;

  out_state_t                  r_state;
  logic [WIDTH-1:0]            r_out_data;
  logic [CW-1:0]               r_out_chan;
  logic [CW-1:0]               r_last_grant;

  for (genvar c = 0; c < NCHAN; c++) begin : g_lane
    assign in_ready[c]         = !w_full[c] && !rst;
    assign w_push[c]           = in_valid[c] && in_ready[c];
    assign w_pop[c]            = w_take && (w_grant == CW'(c));
    assign level[c*LW +: LW]   = w_count[c];

    chan_fifo_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[c]),
      .i_data  (in_data[c*WIDTH +: WIDTH]),
      .i_pop   (w_pop[c]),
      .o_data  (w_lane_data[c]),
      .o_full  (w_full[c]),
      .o_empty (w_empty[c]),
      .o_count (w_count[c])
    );
  end

  // Eligibility comes from registered counts, so same-edge pushes wait a cycle.
  assign w_req  = ~w_empty;
  assign w_load = (r_state == OS_EMPTY) || out_ready;
  assign w_take = w_load && (|w_req);

  always_comb begin
    w_grant = CW'(next_rr(int'(r_last_grant), MAX_CHAN'(w_req), NCHAN));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) w_state_nxt = w_take ? OS_HOLD : OS_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= OS_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_last_grant <= CW'(NCHAN - 1);
    end else if (w_take) begin
      r_out_data   <= w_lane_data[w_grant];
      r_out_chan   <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  assign out_valid = (r_state == OS_HOLD);
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

`ifdef CHAN_FIFO_STALL_CNT_EN
  logic [NCHAN-1:0][STALL_W-1:0] r_stall;

  for (genvar c = 0; c < NCHAN; c++) begin : g_stall
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stall[c] <= '0;
      end else if (in_valid[c] && !in_ready[c] && (r_stall[c] != '1)) begin
        r_stall[c] <= r_stall[c] + STALL_W'(1);
      end
    end
    assign stall_count[c*STALL_W +: STALL_W] = r_stall[c];
  end
`endif

endmodule

// File: tb/tb_chan_fifo_arb.sv
// Directed self-checking bench for chan_fifo_arb (WIDTH=8, DEPTH=4, NCHAN=4).
module tb_chan_fifo_arb;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NCHAN = 4;
  localparam int LW    = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NCHAN-1:0]           in_valid;
  logic [NCHAN*WIDTH-1:0]     in_data;
  logic [NCHAN-1:0]           in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [1:0]                 out_chan;
  logic                       out_ready;
  logic [NCHAN*LW-1:0]        level;
`ifdef CHAN_FIFO_STALL_CNT_EN
  logic [NCHAN*16-1:0]        stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chan_fifo_arb #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NCHAN (NCHAN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_ready   (out_ready),
    .level       (level)
`ifdef CHAN_FIFO_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] lvl(input int c);
    return level[c*LW +: LW];
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held 3 cycles with every lane offering
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", in_ready, 4'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_level", level, 12'h000);
    end
    rst      = 1'b0;
    in_valid = '0;
    #1;
    chk("rel_in_ready", in_ready, 4'hF);
    chk("rel_out_data", out_data, 8'h00);
    chk("rel_out_chan", out_chan, 2'd0);

    // Single word on lane 2
    out_ready          = 1'b1;
    in_valid           = 4'b0100;
    in_data[2*8 +: 8]  = 8'hA5;
    tick();
    in_valid = '0;
    chk("sw_valid_t", out_valid, 1'b0);
    chk("sw_level_t", lvl(2), 3'd1);
    tick();
    chk("sw_valid_t1", out_valid, 1'b1);
    chk("sw_data_t1", out_data, 8'hA5);
    chk("sw_chan_t1", out_chan, 2'd2);
    chk("sw_level_t1", lvl(2), 3'd0);
    tick();
    chk("sw_valid_t2", out_valid, 1'b0);

    // Round robin from a fresh reset
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data   = {8'h30, 8'h20, 8'h10, 8'h00};
    tick();
    in_data   = {8'h31, 8'h21, 8'h11, 8'h01};
    tick();
    in_valid  = '0;
    chk("rr_valid0", out_valid, 1'b1);
    chk("rr_chan0", out_chan, 2'd0);
    chk("rr_data0", out_data, 8'h00);
    chk("rr_level0", level, {3'd2, 3'd2, 3'd2, 3'd1});
    out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("rr_chan", out_chan, 32'(i % 4));
      chk("rr_data", out_data, {24'h0, 4'(i % 4), 4'(i / 4)});
    end
    tick();
    chk("rr_drained", out_valid, 1'b0);
    chk("rr_level_end", level, 12'h000);

    // Full lane 1 with output stalled
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      in_data[1*8 +: 8] = 8'h50 + 8'(k);
      tick();
    end
    chk("full_level", lvl(1), 3'd4);
    chk("full_ready", in_ready[1], 1'b0);
    chk("full_hold_data", out_data, 8'h50);
    chk("full_hold_chan", out_chan, 2'd1);
    in_data[1*8 +: 8] = 8'h55;
    tick();
    chk("full_refused", lvl(1), 3'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_level", lvl(1), 3'd3);
    chk("full_pop_data", out_data, 8'h51);
    chk("full_reopen", in_ready[1], 1'b1);
    tick();
    in_valid = '0;
    chk("full_6th_taken", lvl(1), 3'd4);
    chk("full_data_stable", out_data, 8'h51);

    // Reset mid-operation discards everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", level, 12'h000);
    chk("mid_rst_valid", out_valid, 1'b0);

    // Backpressure while holding 8'h3C
    in_valid          = 4'b0011;
    in_data[0*8 +: 8] = 8'h3C;
    in_data[1*8 +: 8] = 8'h77;
    tick();
    in_valid = '0;
    tick();
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_data", out_data, 8'h3C);
    chk("bp_chan", out_chan, 2'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stall_valid", out_valid, 1'b1);
      chk("bp_stall_data", out_data, 8'h3C);
      chk("bp_stall_chan", out_chan, 2'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_next_data", out_data, 8'h77);
    chk("bp_next_chan", out_chan, 2'd1);
    chk("bp_next_level", lvl(1), 3'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_empty", out_valid, 1'b0);

`ifdef CHAN_FIFO_STALL_CNT_EN
    // Stall counter on a full lane 0
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      in_data[0*8 +: 8] = 8'h90 + 8'(k);
      tick();
    end
    chk("st_full", in_ready[0], 1'b0);
    chk("st_zero", stall_count[15:0], 16'd0);
    for (int k = 0; k < 7; k++) tick();
    in_valid = '0;
    chk("st_count7", stall_count[15:0], 16'd7);
    chk("st_other", stall_count[63:16], 48'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_cleared", stall_count, 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_fifo_arb.md
# chan_fifo_arb

Parametrised multi-channel buffered arbiter: NCHAN independent input lanes, each with its own DEPTH-entry FIFO, merged onto one valid/ready output stream by a round-robin arbiter. It is the next-generation replacement for the single-lane fixed-width merge logic in the Verilog regression designs. It generalises channel count, data width and depth, and adds per-lane occupancy reporting. It sits between stimulus generators and the single checker stream in the simulator regression benches.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, entries per lane FIFO (power of two, >=2)
- NCHAN, 4, number of input lanes (>=2)
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- in_valid  input  NCHAN  per-lane word offered
- in_data  input  NCHAN*WIDTH  lane c data at bits [c*WIDTH +: WIDTH]
- in_ready  output  NCHAN  per-lane space available
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  output word
- out_chan  output  $clog2(NCHAN)  source lane of out_data
- out_ready  input  1  consumer accepts the output word
- level  output  NCHAN*($clog2(DEPTH)+1)  per-lane occupancy, lane c at [c*LW +: LW], where LW=$clog2(DEPTH)+1
- stall_count  output  NCHAN*16  per-lane stall counters; present only with CHAN_FIFO_STALL_CNT_EN

## Operation
- Lane push: occurs when in_valid[c] && in_ready[c] at a clk edge. in_ready[c] = !full[c] && !rst, combinational from registered state.
- Full lane: in_ready[c]=0 and the word is not taken. The producer must hold the word. A pop on the same edge does not reopen ready that cycle.
- Pop and push on the same lane in the same edge: both take effect and the count is unchanged.
- Output stage has two states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; out_data and out_chan are stable until accepted.
- Load condition: (EMPTY) || (HOLD && out_ready).
  - When loading and some lane is non-empty, pop the granted lane and go to (or stay in) HOLD.
  - When loading and no lane is non-empty, go to EMPTY.
- Round robin: last_grant register. Search order is last_grant+1, +2, … modulo NCHAN. The first non-empty lane wins and last_grant is updated to it.
- Arbitration uses registered lane counts only. A word pushed on edge t is not eligible until edge t+1.
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap naturally. The count is LW bits, 0..DEPTH.
- Reset values:
  - all pointers and counts 0
  - out_valid=0, out_data=0, out_chan=0
  - last_grant=NCHAN-1, so lane 0 is served first
  - level all 0; stall_count all 0
  - in_ready all 0 while rst=1
- Reset mid-operation discards all buffered words and any held output word. There is no partial drain.

## Timing
- Latency: a word pushed into an empty lane on edge t, with the output stage EMPTY, appears with out_valid=1 after edge t+1.
- Throughput: with out_ready held high and words available, one word per cycle.
- level updates on the same edge as the push or pop.
- out_valid never drops without out_ready, except on reset.

## Configuration
- CHAN_FIFO_STALL_CNT_EN defined:
  - stall_count port exists.
  - Lane c counter increments on each edge where in_valid[c] && !in_ready[c] and rst=0.
  - Counters saturate at 16'hFFFF; reset clears them.
- Not defined: port, counters and logic are absent, and the rest of the behaviour is identical.

## Structure
- Package chan_fifo_pkg holds:
  - out_state_t enum {OS_EMPTY, OS_HOLD}
  - STALL_W=16 localparam
  - a function next_rr(last, req_mask) returning the granted index
- Sub-module chan_fifo_lane: single DEPTH×WIDTH FIFO with push, pop, full, empty and count. It is instantiated NCHAN times in a generate-for loop.
- Top level holds the arbiter, output register and the optional stall counters.

## Test plan
- Reset: hold rst 3 cycles with in_valid=all 1s -> in_ready=0, out_valid=0, level=0 throughout. After release, in_ready=all 1s.
- Single word: lane 2 pushes 8'hA5 on edge t, out_ready=1 -> after edge t+1, out_valid=1, out_data=8'hA5, out_chan=2. After edge t+2, out_valid=0.
- Round robin: all 4 lanes preloaded with words {c,0},{c,1}, then out_ready=1 -> out_chan sequence is 0,1,2,3,0,1,2,3 with data matching.
- Full lane: push 5 words to lane 1 with out_ready=0 -> 4 accepted after the first drains to HOLD, leaving level[1]=4 and in_ready[1]=0. The 6th offered word is held by the producer and is accepted after one pop.
- Backpressure: out_ready=0 for 10 cycles while holding 8'h3C -> out_data and out_chan are stable. On the out_ready pulse the next lane's word loads on the same edge.
- With CHAN_FIFO_STALL_CNT_EN: lane 0 full, in_valid[0]=1 for 7 cycles -> stall_count lane 0 equals 7. Another reset clears it to 0.
